// File: rtl/inverse_matrix_if.sv
// Start/done coprocessor bus for the 2x2 matrix inverter.
// master: the requester driving start and the matrix; slave: the inverter.
interface inverse_matrix_if #(
  parameter int W    = 8,
  parameter int FRAC = 8
);
  logic                     start;
  logic signed [W-1:0]      a00, a01, a10, a11;
  logic                     busy;
  logic                     done;
  logic                     singular;
  logic signed [2*W-1:0]    det;
  logic signed [W+FRAC:0]   inv00, inv01, inv10, inv11;

  modport master (
    output start, a00, a01, a10, a11,
    input  busy, done, singular, det, inv00, inv01, inv10, inv11
  );

  modport slave (
    input  start, a00, a01, a10, a11,
    output busy, done, singular, det, inv00, inv01, inv10, inv11
  );
endinterface

// File: rtl/inverse_matrix.sv
// Sequential 2x2 signed matrix inverter: det, then adj/det through one shared
// restoring divider (one quotient bit per cycle, four elements in turn).
// Optional macro INV_ROUND_EN: round each quotient to nearest (ties away from
// zero) instead of truncating toward zero.
module inverse_matrix #(
  parameter int W    = 8,
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  inverse_matrix_if.slave   bus
);
  localparam int QW = W + FRAC + 1;   // quotient / inverse element width
  localparam int DW = 2 * W;          // determinant width
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {S_IDLE, S_DET, S_DIV, S_FIN} state_t;

  state_t                 state, state_nx;
  logic signed [W-1:0]    a00_r, a01_r, a10_r, a11_r;
  logic signed [DW-1:0]   x00, x01, x10, x11;
  logic signed [DW-1:0]   det_c;
  logic [DW-1:0]          det_mag;

  logic [QW-1:0]          dvd;        // dividend, MSB shifted out first
  logic [DW:0]            rem;
  logic [QW-1:0]          quo;
  logic [CW-1:0]          bit_cnt;
  logic [1:0]             elem;       // element currently being divided
  logic                   q_neg;      // sign of the current quotient

  logic                   busy_q, done_q, sing_q;
  logic signed [DW-1:0]   det_q;
  logic signed [QW-1:0]   inv_q [4];

  logic [1:0]             ld_idx;
  logic signed [W-1:0]    src;
  logic                   src_flip;
  logic [W-1:0]           src_mag;
  logic [QW-1:0]          ld_dvd;
  logic                   ld_neg;
  logic [DW:0]            rem_sh;
  logic                   fits;
  logic [DW:0]            rem_nx;
  logic [QW-1:0]          quo_nx;
  logic signed [QW-1:0]   res;
  logic                   last_bit;

  // Full-precision determinant of the latched matrix; inputs are frozen while busy.
  assign x00     = DW'(a00_r);
  assign x01     = DW'(a01_r);
  assign x10     = DW'(a10_r);
  assign x11     = DW'(a11_r);
  assign det_c   = x00 * x11 - x01 * x10;
  assign det_mag = det_c[DW-1] ? -det_c : det_c;

  assign last_bit = (bit_cnt == CW'(QW - 1));
  assign ld_idx   = (state == S_DET) ? 2'd0 : elem + 2'd1;

  // Pick the adjugate element to load next and form its dividend magnitude and sign.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src      = a11_r;
    src_flip = 1'b0;
    case (ld_idx)
      2'd0:    begin src = a11_r; src_flip = 1'b0; end
      2'd1:    begin src = a01_r; src_flip = 1'b1; end
      2'd2:    begin src = a10_r; src_flip = 1'b1; end
      default: begin src = a00_r; src_flip = 1'b0; end
    endcase
    src_mag = src[W-1] ? -src : src;
    ld_neg  = src[W-1] ^ src_flip ^ det_c[DW-1];
`ifdef INV_ROUND_EN
    ld_dvd  = QW'({src_mag, {FRAC{1'b0}}}) + QW'(det_mag >> 1);
`else
    ld_dvd  = QW'({src_mag, {FRAC{1'b0}}});
`endif
  end

  // One restoring-division step: trial subtract of |det| from the shifted remainder.
  always_comb begin
    rem_sh = {rem[DW-1:0], dvd[QW-1]};
    fits   = (rem_sh >= {1'b0, det_mag});
    rem_nx = fits ? rem_sh - {1'b0, det_mag} : rem_sh;
    quo_nx = {quo[QW-2:0], fits};
    res    = q_neg ? -quo_nx : quo_nx;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_DET;
      S_DET:  state_nx = (det_c == '0) ? S_FIN : S_DIV;
      S_DIV:  if (last_bit && elem == 2'd3) state_nx = S_FIN;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a00_r   <= '0; a01_r <= '0; a10_r <= '0; a11_r <= '0;
      dvd     <= '0; rem   <= '0; quo   <= '0;
      bit_cnt <= '0; elem  <= '0; q_neg <= 1'b0;
      busy_q  <= 1'b0; done_q <= 1'b0; sing_q <= 1'b0;
      det_q   <= '0;
      // NOTE: this small result array is reset explicitly because it is architecturally visible.
      for (int i = 0; i < 4; i++) inv_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a00_r  <= bus.a00; a01_r <= bus.a01;
            a10_r  <= bus.a10; a11_r <= bus.a11;
            busy_q <= 1'b1;
            sing_q <= 1'b0;
            det_q  <= '0;
            for (int i = 0; i < 4; i++) inv_q[i] <= '0;
          end
        end
        S_DET: begin
          det_q   <= det_c;
          sing_q  <= (det_c == '0);
          dvd     <= ld_dvd;
          rem     <= '0;
          quo     <= '0;
          bit_cnt <= '0;
          elem    <= 2'd0;
          q_neg   <= ld_neg;
        end
        S_DIV: begin
          if (last_bit) begin
            inv_q[elem] <= res;
            dvd     <= ld_dvd;
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
            elem    <= elem + 2'd1;
            q_neg   <= ld_neg;
          end else begin
            dvd     <= dvd << 1;
            rem     <= rem_nx;
            quo     <= quo_nx;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.singular = sing_q;
  assign bus.det      = det_q;
  assign bus.inv00    = inv_q[0];
  assign bus.inv01    = inv_q[1];
  assign bus.inv10    = inv_q[2];
  assign bus.inv11    = inv_q[3];
endmodule

// File: tb/tb_inverse_matrix.sv
// Scoreboard bench for inverse_matrix: the driver pushes model results, a
// monitor pops and compares on every done pulse.
module tb_inverse_matrix;
  localparam int W    = 8;
  localparam int FRAC = 8;
  localparam int QW   = W + FRAC + 1;

  typedef struct {
    int det;
    int sing;
    int inv [4];
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb [$];

  inverse_matrix_if #(.W(W), .FRAC(FRAC)) bus ();
  inverse_matrix #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: inverse of a 2x2 matrix with plain integer arithmetic.
  function automatic exp_t model(input int m00, input int m01, input int m10, input int m11);
    exp_t e;
    int   adj [4];
    int   d, dm, num, nm, q;
    d = m00 * m11 - m01 * m10;
    adj[0] = m11; adj[1] = -m01; adj[2] = -m10; adj[3] = m00;
    e.det  = d;
    e.sing = (d == 0);
    dm = (d < 0) ? -d : d;
    for (int k = 0; k < 4; k++) begin
      if (d == 0) begin
        e.inv[k] = 0;
      end else begin
        num = adj[k] * (1 << FRAC);
        nm  = (num < 0) ? -num : num;
`ifdef INV_ROUND_EN
        q = (nm + dm / 2) / dm;
`else
        q = nm / dm;
`endif
        e.inv[k] = ((num < 0) != (d < 0)) ? -q : q;
      end
    end
    e.cyc = (d == 0) ? 2 : 2 + 4 * QW;
    return e;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_singular"}, bus.singular, 0);
    check({tag, "_det"}, int'(bus.det), 0);
    check({tag, "_inv00"}, int'(bus.inv00), 0);
    check({tag, "_inv01"}, int'(bus.inv01), 0);
    check({tag, "_inv10"}, int'(bus.inv10), 0);
    check({tag, "_inv11"}, int'(bus.inv11), 0);
  endtask

  // Issue one operation, disturb inputs/start while busy, wait for done.
  task automatic run_op(input int m00, input int m01, input int m10, input int m11);
    exp_t e;
    bit   seen;
    e = model(m00, m01, m10, m11);
    bus.a00 = W'(m00); bus.a01 = W'(m01);
    bus.a10 = W'(m10); bus.a11 = W'(m11);
    bus.start = 1'b1;
    e.cyc = cyc + 1 + e.cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (i == 3) begin
        bus.start = 1'b1;
        bus.a00 = W'($urandom); bus.a01 = W'($urandom);
        bus.a10 = W'($urandom); bus.a11 = W'($urandom);
      end
      if (i == 4) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("det", int'(bus.det), e.det);
          check("singular", bus.singular, e.sing);
          check("inv00", int'(bus.inv00), e.inv[0]);
          check("inv01", int'(bus.inv01), e.inv[1]);
          check("inv10", int'(bus.inv10), e.inv[2]);
          check("inv11", int'(bus.inv11), e.inv[3]);
          check("done_cycle", cyc, e.cyc);
          check("busy_at_done", bus.busy, 0);
        end
      end
    end
  end

  function automatic int pick();
    int v;
    case ($urandom_range(0, 5))
      0: v = -128;
      1: v = 127;
      2: v = 0;
      3: v = ($urandom_range(0, 1) == 1) ? 1 : -1;
      default: v = int'($signed(8'($urandom)));
    endcase
    return v;
  endfunction

  initial begin
    int r00, r01, r10, r11;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a00 = '0; bus.a01 = '0; bus.a10 = '0; bus.a11 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_op(1, 0, 0, 1);
    run_op(4, 7, 2, 6);
    run_op(1, 2, 2, 4);
    run_op(-128, 1, -1, 0);

    // Second start while busy, then reset mid-operation: no done must follow.
    bus.a00 = 8'sd1; bus.a01 = 8'sd0; bus.a10 = 8'sd0; bus.a11 = 8'sd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.a00 = 8'sd5; bus.a01 = 8'sd3; bus.a10 = 8'sd2; bus.a11 = 8'sd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_ignores_start", bus.busy, 1);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("abort");
    repeat (80) @(posedge clk);
    #1;
    check_idle_zero("after_abort");
    run_op(2, 0, 0, 4);

    // Randomized operations, issued back to back.
    for (int n = 0; n < 40; n++) begin
      r00 = pick(); r01 = pick(); r10 = pick(); r11 = pick();
      if ($urandom_range(0, 4) == 0) begin
        r10 = r00; r11 = r01;
      end
      run_op(r00, r01, r10, r11);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inverse_matrix.md
Name: inverse_matrix

Overview:
- Sequential fixed-point inverter for a 2x2 signed integer matrix [[a00,a01],[a10,a11]].
- Computes det = a00*a11 - a01*a10, then inv = adj/det, with adj = [[a11,-a01],[-a10,a00]].
- Outputs are signed Q(W+1).FRAC values.
- Sits as a coprocessor behind a start/done handshake. One shared bit-serial divider produces the four elements in turn.

Parameters:
- W, 8, width of each signed input element.
- FRAC, 8, fractional bits of each inverse element.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a00, a01, a10, a11  input  W each  signed matrix elements; sampled on the edge that accepts start.
- busy  output  1  high from the accept edge until done.
- done  output  1  single-cycle completion pulse.
- singular  output  1  det==0 for the last operation; valid with done, held until the next accept.
- det  output  2W  signed determinant, registered.
- inv00, inv01, inv10, inv11  output  W+FRAC+1 each  signed inverse elements; LSB weight 2^-FRAC.

Behaviour:
- Reset: one clk edge with rst=1 forces state IDLE and clears busy, done, singular, det and all inv* to 0. Reset mid-operation aborts the operation, clears all outputs and produces no done.
- States and transitions:
  - IDLE: start=1 latches the inputs and sets busy=1, then goes to DET.
  - DET (1 cycle): registers det. If det==0, goes to FIN with singular=1 and inv*=0. Otherwise goes to DIV.
  - DIV: four divisions in order inv00, inv01, inv10, inv11. Each is restoring, 1 quotient bit per cycle, Q=W+FRAC+1 cycles. Then goes to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency, counted in rising edges after the accept edge:
  - done asserts after 2+4*(W+FRAC+1) edges; 70 for the defaults.
  - Singular case: done asserts after 2 edges.
- Back-to-back: start is honoured in the cycle after done, when state is IDLE.
- start while busy is ignored. Input changes while busy are ignored.
- Arithmetic:
  - det is computed at full 2W-bit signed precision; no overflow is possible.
  - Each division: dividend = |adj_elem| << FRAC, divisor = |det|. Quotient sign = sign(adj_elem) XOR sign(det). Result truncates toward zero.
  - W+FRAC+1 bits hold the worst case, |adj|=2^(W-1) with |det|=1, so no saturation logic is required.
- inv* registers update only when their own division completes. They hold their values until the next accept edge clears them to 0.

Optional Feature:
- Macro INV_ROUND_EN.
- Defined: each division rounds to nearest, ties away from zero, by adding |det|>>1 to the dividend magnitude before dividing. Latency is unchanged.
- Undefined: truncation toward zero as specified above.

Test Plan:
- Identity [[1,0],[0,1]] -> det=1, inv00=256, inv01=0, inv10=0, inv11=256, singular=0; done exactly 70 edges after accept.
- [[4,7],[2,6]] -> det=10, inv00=153, inv01=-179, inv10=-51, inv11=102. With INV_ROUND_EN: 154, -179, -51, 102.
- Singular [[1,2],[2,4]] -> det=0, singular=1, all inv*=0, done 2 edges after accept.
- Extreme [[-128,1],[-1,0]] -> det=1, inv00=0, inv01=-256, inv10=256, inv11=-32768 (no overflow).
- Pulse start again at cycle 10 of the identity run, then rst=1 at cycle 30 -> second start ignored; after the rst edge busy=0, done never pulses, all outputs are 0. A fresh start on [[2,0],[0,4]] then yields det=8, inv00=128, inv11=64.
